// File: rtl/usb_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_pkg
//  Description : Shared types and constants for the USB full-speed transmit
//                serializer: FSM state encoding, SYNC/stuff/EOP constants
//                and single-ended line-state codes ({dp, dn}).
//  Revision    : 1.0 - initial release
// ============================================================================
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } tx_state_t;

    localparam logic [7:0] SYNC_BYTE    = 8'h80;
    localparam logic [2:0] STUFF_LIMIT  = 3'd6;
    localparam int         EOP_SE0_BITS = 2;

    // Line states as {dp, dn}
    typedef logic [1:0] line_t;
    localparam line_t LINE_J   = 2'b10;
    localparam line_t LINE_K   = 2'b01;
    localparam line_t LINE_SE0 = 2'b00;

    // NRZI level 1 is J, level 0 is K.
    function automatic line_t nrzi_line(input logic level);
        return level ? LINE_J : LINE_K;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_nrzi_stuff.sv
`default_nettype none
// ============================================================================
//  Module      : usb_nrzi_stuff
//  Description : Bit-stuffing counter plus NRZI level register.
//                clk, rst_n  : clock, async active-low reset
//                clear       : hold level at J and ones count at 0 (idle)
//                bit_tick    : a bit is emitted this cycle; commit it
//                bit_in      : data bit offered (ignored while stall=1)
//                stall       : six ones seen; this bit time is a stuffed 0
//                level_next  : NRZI level of the bit being emitted (1 = J)
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_nrzi_stuff
    import usb_tx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic bit_tick,
    input  logic bit_in,
    output logic stall,
    output logic level_next
);

    logic [2:0] r_ones;
    logic       r_level;
    logic       w_bit;

    assign stall      = (r_ones == STUFF_LIMIT);
    // A stuffed bit is always a 0, i.e. a forced transition.
    assign w_bit      = stall ? 1'b0 : bit_in;
    assign level_next = w_bit ? r_level : ~r_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones  <= 3'd0;
            r_level <= 1'b1;
        end else if (clear) begin
            r_ones  <= 3'd0;
            r_level <= 1'b1;
        end else if (bit_tick) begin
            r_level <= level_next;
            r_ones  <= w_bit ? (r_ones + 3'd1) : 3'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/usb_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : usb_tx_serializer
//  Description : Link-layer byte stream to full-speed USB wire. Prepends
//                SYNC, shifts bytes LSB-first, bit-stuffs, NRZI-encodes and
//                appends SE0 SE0 J.
//                tx_to_sop/eop/valid/data : byte stream in, tx_to_ready out
//                tx_dp/tx_dn/tx_oe        : registered pad drive
//                tx_busy                  : SOP accepted until EOP done
//                tx_underrun              : 1-clk pulse, byte missing mid-packet
//  Revision    : 1.0 - initial release
// ============================================================================
module usb_tx_serializer
    import usb_tx_pkg::*;
#(
    parameter int BIT_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_to_sop,
    input  logic       tx_to_eop,
    input  logic       tx_to_valid,
    output logic       tx_to_ready,
    input  logic [7:0] tx_to_data,
    output logic       tx_dp,
    output logic       tx_dn,
    output logic       tx_oe,
    output logic       tx_busy,
    output logic       tx_underrun
);

    localparam logic [7:0] C_DIV_LAST  = 8'(BIT_DIV - 1);
    localparam logic [3:0] C_BYTE_DONE = 4'd8;
    localparam logic [3:0] C_SE0_LAST  = 4'(EOP_SE0_BITS);

    tx_state_t  r_state,     w_state_nxt;
    logic [7:0] r_div,       w_div_nxt;
    logic [3:0] r_bit_cnt,   w_bit_cnt_nxt;
    logic [7:0] r_shift,     w_shift_nxt;
    logic       r_cur_eop,   w_cur_eop_nxt;
    logic [7:0] r_hold_data, w_hold_data_nxt;
    logic       r_hold_eop,  w_hold_eop_nxt;
    logic       r_hold_full, w_hold_full_nxt;
    logic       r_dp,        w_dp_nxt;
    logic       r_dn,        w_dn_nxt;
    logic       r_oe,        w_oe_nxt;
    logic       r_busy,      w_busy_nxt;
    logic       r_underrun,  w_underrun_nxt;

    logic w_tick;
    logic w_nrzi_adv;
    logic w_bit_in;
    logic w_stall;
    logic w_level_next;

    assign w_tick      = (r_state != IDLE) && (r_div == C_DIV_LAST);
    assign tx_dp       = r_dp;
    assign tx_dn       = r_dn;
    assign tx_oe       = r_oe;
    assign tx_busy     = r_busy;
    assign tx_underrun = r_underrun;

    usb_nrzi_stuff u_nrzi_stuff (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (r_state == IDLE),
        .bit_tick   (w_nrzi_adv),
        .bit_in     (w_bit_in),
        .stall      (w_stall),
        .level_next (w_level_next)
    );

    // Ready depends only on state and holder occupancy, so a byte can never
    // be accepted in the same cycle the holder is drained.
    always_comb begin
        tx_to_ready = 1'b0;
        case (r_state)
            IDLE:       tx_to_ready = 1'b1;
            SYNC, DATA: tx_to_ready = ~r_hold_full;
            default:    tx_to_ready = 1'b0;
        endcase
    end

    // Which NRZI bit (if any) goes on the wire at this tick. Kept apart from
    // the FSM so the line level can be read back without a comb loop.
    always_comb begin
        w_nrzi_adv = 1'b0;
        w_bit_in   = 1'b0;
        if (w_tick) begin
            case (r_state)
                SYNC: begin
                    w_nrzi_adv = 1'b1;
                    w_bit_in   = SYNC_BYTE[r_bit_cnt[2:0]];
                end
                DATA: begin
                    if (w_stall) begin
                        w_nrzi_adv = 1'b1;
                    end else if (r_bit_cnt != C_BYTE_DONE) begin
                        w_nrzi_adv = 1'b1;
                        w_bit_in   = r_shift[0];
                    end else if (!r_cur_eop && r_hold_full) begin
                        w_nrzi_adv = 1'b1;
                        w_bit_in   = r_hold_data[0];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_div_nxt       = r_div;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_cur_eop_nxt   = r_cur_eop;
        w_hold_data_nxt = r_hold_data;
        w_hold_eop_nxt  = r_hold_eop;
        w_hold_full_nxt = r_hold_full;
        w_dp_nxt        = r_dp;
        w_dn_nxt        = r_dn;
        w_oe_nxt        = r_oe;
        w_busy_nxt      = r_busy;
        w_underrun_nxt  = 1'b0;

        if (r_state == IDLE) begin
            w_div_nxt = 8'd0;
        end else begin
            w_div_nxt = w_tick ? 8'd0 : (r_div + 8'd1);
        end

        // Mid-packet acceptance into the holder.
        if (tx_to_valid && tx_to_ready && (r_state != IDLE)) begin
            w_hold_data_nxt = tx_to_data;
            w_hold_eop_nxt  = tx_to_eop;
            w_hold_full_nxt = 1'b1;
        end

        // Whatever the state, an emitted NRZI bit drives the line.
        if (w_nrzi_adv) begin
            {w_dp_nxt, w_dn_nxt} = nrzi_line(w_level_next);
            w_oe_nxt             = 1'b1;
        end

        case (r_state)
            IDLE: begin
                // Non-SOP bytes are accepted and dropped.
                if (tx_to_valid && tx_to_sop) begin
                    w_hold_data_nxt = tx_to_data;
                    w_hold_eop_nxt  = tx_to_eop;
                    w_hold_full_nxt = 1'b1;
                    w_busy_nxt      = 1'b1;
                    w_bit_cnt_nxt   = 4'd0;
                    w_state_nxt     = SYNC;
                end
            end
            SYNC: begin
                if (w_tick) begin
                    if (r_bit_cnt == 4'd7) begin
                        // Byte "exhausted": first DATA tick pulls the holder.
                        w_bit_cnt_nxt = C_BYTE_DONE;
                        w_cur_eop_nxt = 1'b0;
                        w_state_nxt   = DATA;
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (w_tick && !w_stall) begin
                    if (r_bit_cnt != C_BYTE_DONE) begin
                        w_shift_nxt   = {1'b0, r_shift[7:1]};
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (r_cur_eop) begin
                        {w_dp_nxt, w_dn_nxt} = LINE_SE0;
                        w_bit_cnt_nxt        = 4'd1;
                        w_state_nxt          = EOP_SE0;
                    end else if (r_hold_full) begin
                        // Bit 0 of the new byte goes out now; keep the rest.
                        w_shift_nxt     = {1'b0, r_hold_data[7:1]};
                        w_cur_eop_nxt   = r_hold_eop;
                        w_hold_full_nxt = 1'b0;
                        w_bit_cnt_nxt   = 4'd1;
                    end else begin
                        w_underrun_nxt       = 1'b1;
                        {w_dp_nxt, w_dn_nxt} = LINE_SE0;
                        w_bit_cnt_nxt        = 4'd1;
                        w_state_nxt          = EOP_SE0;
                    end
                end
            end
            EOP_SE0: begin
                if (w_tick) begin
                    if (r_bit_cnt < C_SE0_LAST) begin
                        {w_dp_nxt, w_dn_nxt} = LINE_SE0;
                        w_bit_cnt_nxt        = r_bit_cnt + 4'd1;
                    end else begin
                        {w_dp_nxt, w_dn_nxt} = LINE_J;
                        w_state_nxt          = EOP_J;
                    end
                end
            end
            EOP_J: begin
                if (w_tick) begin
                    {w_dp_nxt, w_dn_nxt} = LINE_J;
                    w_oe_nxt             = 1'b0;
                    w_busy_nxt           = 1'b0;
                    w_hold_full_nxt      = 1'b0;
                    w_state_nxt          = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_div       <= 8'd0;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 8'd0;
            r_cur_eop   <= 1'b0;
            r_hold_data <= 8'd0;
            r_hold_eop  <= 1'b0;
            r_hold_full <= 1'b0;
            r_dp        <= 1'b1;
            r_dn        <= 1'b0;
            r_oe        <= 1'b0;
            r_busy      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_div       <= w_div_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_cur_eop   <= w_cur_eop_nxt;
            r_hold_data <= w_hold_data_nxt;
            r_hold_eop  <= w_hold_eop_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_dp        <= w_dp_nxt;
            r_dn        <= w_dn_nxt;
            r_oe        <= w_oe_nxt;
            r_busy      <= w_busy_nxt;
            r_underrun  <= w_underrun_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_tx_serializer
//  Description : Directed self-checking bench for usb_tx_serializer.
//                A negedge monitor records the line while tx_oe is high;
//                packets are decoded (NRZI, de-stuff) and compared with
//                hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_tx_serializer;

    localparam logic [1:0] L_J   = 2'b10;
    localparam logic [1:0] L_K   = 2'b01;
    localparam logic [1:0] L_SE0 = 2'b00;

    logic       clk;
    logic       rst_n;
    logic       tx_to_sop;
    logic       tx_to_eop;
    logic       tx_to_valid;
    logic       tx_to_ready;
    logic [7:0] tx_to_data;
    logic       tx_dp;
    logic       tx_dn;
    logic       tx_oe;
    logic       tx_busy;
    logic       tx_underrun;

    int n_cmp = 0;
    int n_mis = 0;

    usb_tx_serializer #(.BIT_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_to_sop   (tx_to_sop),
        .tx_to_eop   (tx_to_eop),
        .tx_to_valid (tx_to_valid),
        .tx_to_ready (tx_to_ready),
        .tx_to_data  (tx_to_data),
        .tx_dp       (tx_dp),
        .tx_dn       (tx_dn),
        .tx_oe       (tx_oe),
        .tx_busy     (tx_busy),
        .tx_underrun (tx_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line monitor
    logic [1:0] line_q[$];
    int         urun_clks = 0;
    int         urun_at   = -1;
    always @(negedge clk) begin
        if (tx_oe) line_q.push_back({tx_dp, tx_dn});
        if (tx_underrun) begin
            urun_clks = urun_clks + 1;
            urun_at   = line_q.size() - 1;
        end
    end

    // Decoder results
    logic [7:0]  dec_bytes[$];
    int          stuff_at[$];
    logic [7:0]  dec_sync;
    logic [63:0] dec_line;
    logic        dec_eop_ok;
    int          dec_partial;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int n;
        tx_to_valid = 1'b1;
        tx_to_data  = d;
        tx_to_sop   = s;
        tx_to_eop   = e;
        n = 0;
        while (!tx_to_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 64'(n < 500), 64'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 64'(n < 2000), 64'd1);
    endtask

    // Samples one code per bit time (first clk of each 4-clk bit).
    task automatic analyze(input int start);
        int nbits, se0_at, ones, nd;
        logic prev, lvl, b;
        logic [7:0] sh;
        logic [1:0] c;
        nbits  = (line_q.size() - start) / 4;
        se0_at = -1;
        ones   = 0;
        nd     = 0;
        prev   = 1'b1;
        sh     = 8'd0;
        dec_bytes.delete();
        stuff_at.delete();
        dec_sync = 8'd0;
        dec_line = 64'd0;
        for (int i = 0; i < nbits; i++) begin
            c        = line_q[start + 4 * i];
            dec_line = {dec_line[61:0], c};
            if (se0_at < 0) begin
                if (c == L_SE0) begin
                    se0_at = i;
                end else begin
                    lvl  = (c == L_J);
                    b    = (lvl == prev);
                    prev = lvl;
                    if (i < 8) begin
                        dec_sync[i] = b;
                        ones = b ? ones + 1 : 0;
                    end else if (ones == 6) begin
                        stuff_at.push_back(nd);
                        ones = 0;
                    end else begin
                        ones = b ? ones + 1 : 0;
                        sh   = {b, sh[7:1]};
                        nd++;
                        if (nd % 8 == 0) dec_bytes.push_back(sh);
                    end
                end
            end
        end
        dec_partial = nd % 8;
        dec_eop_ok  = (se0_at >= 0) && (nbits == se0_at + 3)
                      && (line_q[start + 4 * (se0_at + 1)] == L_SE0)
                      && (line_q[start + 4 * (se0_at + 2)] == L_J);
    endtask

    task automatic run_ack(input string tag);
        int mark;
        mark = line_q.size();
        send_byte(8'hD2, 1'b1, 1'b1);
        chk({tag, "_busy"}, 64'(tx_busy), 64'd1);
        tx_to_valid = 1'b0;
        wait_idle();
        analyze(mark);
        chk({tag, "_oe_clks"}, 64'(line_q.size() - mark), 64'd76);
        chk({tag, "_line"}, dec_line,
            64'(38'b01_10_01_10_01_10_01_01_10_10_01_10_10_01_01_01_00_00_10));
        chk({tag, "_nbytes"}, 64'(dec_bytes.size()), 64'd1);
        chk({tag, "_byte0"}, 64'(dec_bytes[0]), 64'hD2);
        chk({tag, "_oe_after"}, 64'(tx_oe), 64'd0);
        chk({tag, "_ready_after"}, 64'(tx_to_ready), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, u0;
        rst_n       = 1'b0;
        tx_to_sop   = 1'b0;
        tx_to_eop   = 1'b0;
        tx_to_valid = 1'b0;
        tx_to_data  = 8'h00;

        // Reset state
        #12;
        chk("rst_dp", 64'(tx_dp), 64'd1);
        chk("rst_dn", 64'(tx_dn), 64'd0);
        chk("rst_oe", 64'(tx_oe), 64'd0);
        chk("rst_busy", 64'(tx_busy), 64'd0);
        chk("rst_underrun", 64'(tx_underrun), 64'd0);
        chk("rst_ready", 64'(tx_to_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ACK packet
        run_ack("ack");

        // Stuffing: FF FF
        mark = line_q.size();
        send_byte(8'hFF, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b0, 1'b1);
        tx_to_valid = 1'b0;
        wait_idle();
        analyze(mark);
        chk("stuff_oe_clks", 64'(line_q.size() - mark), 64'd116);
        chk("stuff_count", 64'(stuff_at.size()), 64'd2);
        chk("stuff_pos0", 64'(stuff_at[0]), 64'd5);
        chk("stuff_pos1", 64'(stuff_at[1]), 64'd11);
        chk("stuff_sync", 64'(dec_sync), 64'h80);
        chk("stuff_bytes", 64'({dec_bytes[0], dec_bytes[1]}), 64'hFFFF);
        chk("stuff_eop", 64'(dec_eop_ok), 64'd1);

        // Token: E1 15 2E back-to-back
        mark = line_q.size();
        send_byte(8'hE1, 1'b1, 1'b0);
        send_byte(8'h15, 1'b0, 1'b0);
        send_byte(8'h2E, 1'b0, 1'b1);
        tx_to_valid = 1'b0;
        wait_idle();
        analyze(mark);
        chk("tok_oe_clks", 64'(line_q.size() - mark), 64'd140);
        chk("tok_nbytes", 64'(dec_bytes.size()), 64'd3);
        chk("tok_bytes", 64'({dec_bytes[0], dec_bytes[1], dec_bytes[2]}), 64'hE1152E);
        chk("tok_partial", 64'(dec_partial), 64'd0);
        chk("tok_eop", 64'(dec_eop_ok), 64'd1);

        // Underrun: E1 with no eop, then nothing
        mark = line_q.size();
        u0   = urun_clks;
        send_byte(8'hE1, 1'b1, 1'b0);
        tx_to_valid = 1'b0;
        wait_idle();
        analyze(mark);
        chk("urun_pulses", 64'(urun_clks - u0), 64'd1);
        chk("urun_at", 64'(urun_at - mark), 64'd64);
        chk("urun_oe_clks", 64'(line_q.size() - mark), 64'd76);
        chk("urun_byte", 64'(dec_bytes[0]), 64'hE1);
        chk("urun_eop", 64'(dec_eop_ok), 64'd1);

        // Reset in the middle of byte 2
        u0 = urun_clks;
        send_byte(8'hE1, 1'b1, 1'b0);
        send_byte(8'h15, 1'b0, 1'b0);
        tx_to_valid = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid_oe_before", 64'(tx_oe), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_oe", 64'(tx_oe), 64'd0);
        chk("mid_rst_line", 64'({tx_dp, tx_dn}), 64'(L_J));
        chk("mid_rst_ready", 64'(tx_to_ready), 64'd1);
        chk("mid_rst_busy", 64'(tx_busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_no_urun", 64'(urun_clks - u0), 64'd0);

        // Idle noise: non-SOP byte in IDLE is swallowed
        mark = line_q.size();
        send_byte(8'h55, 1'b0, 1'b0);
        tx_to_valid = 1'b0;
        chk("noise_busy", 64'(tx_busy), 64'd0);
        repeat (10) @(negedge clk);
        chk("noise_oe_clks", 64'(line_q.size() - mark), 64'd0);

        // Clean packet after reset and noise
        run_ack("ack2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
